// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - issue/retire/squash bus and debug status of the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int NUM_REGS  = 32,
    parameter int REG_IDX_W = 5
);
    logic                   issue_valid;
    logic [REG_IDX_W-1:0]   issue_rs1;
    logic [REG_IDX_W-1:0]   issue_rs2;
    logic                   issue_rs1_used;
    logic                   issue_rs2_used;
    logic [REG_IDX_W-1:0]   issue_rd;
    logic                   issue_rd_write;
    logic                   issue_stall;
    logic                   retire_valid;
    logic [REG_IDX_W-1:0]   retire_rd;
    logic                   squash_valid;
    logic [REG_IDX_W-1:0]   squash_rd;
    logic [NUM_REGS-1:0]    busy_mask;
    logic [REG_IDX_W+2:0]   inflight_total;
    logic                   error;
    logic [31:0]            stall_cycles;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_write, retire_valid, retire_rd, squash_valid, squash_rd,
        input  issue_stall, busy_mask, inflight_total, error, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_write, retire_valid, retire_rd, squash_valid, squash_rd,
        output issue_stall, busy_mask, inflight_total, error, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write counters with RAW/structural issue stall
module hazard_scoreboard #(
    parameter int NUM_REGS      = 32,
    parameter int REG_IDX_W     = 5,
    parameter int MAX_PENDING   = 3,
    parameter int RETIRE_BYPASS = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    hazard_scoreboard_if.slave    sb
);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int TW = REG_IDX_W + 3;

    logic [CW-1:0]       count_q [NUM_REGS];
    logic [CW-1:0]       count_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [TW-1:0]       total_q, total_d;
    logic                error_q, error_d;
    logic [31:0]         stall_q, stall_d;

    logic [NUM_REGS-1:0] dec_r, dec_s, inc, pending;
    logic                rs1_hit, rs2_hit, rd_full, stall, fire;
    logic                retire_oor, squash_oor, underflow;
    int                  net;

    always_comb begin
        dec_r     = '0;
        dec_s     = '0;
        inc       = '0;
        pending   = '0;
        rs1_hit   = 1'b0;
        rs2_hit   = 1'b0;
        rd_full   = 1'b0;
        underflow = 1'b0;
        net       = 0;
        total_d   = '0;
        busy_d    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_d[i] = '0;
        end

        for (int i = 1; i < NUM_REGS; i++) begin
            dec_r[i] = sb.retire_valid && (sb.retire_rd == REG_IDX_W'(i));
            dec_s[i] = sb.squash_valid && (sb.squash_rd == REG_IDX_W'(i));
            // Bypass mode treats same-cycle decrements as already applied for source checks only.
            if (RETIRE_BYPASS != 0)
                pending[i] = {2'b00, count_q[i]} > ((CW+2)'(dec_r[i]) + (CW+2)'(dec_s[i]));
            else
                pending[i] = count_q[i] != '0;
            if ((sb.issue_rs1 == REG_IDX_W'(i)) && pending[i])
                rs1_hit = 1'b1;
            if ((sb.issue_rs2 == REG_IDX_W'(i)) && pending[i])
                rs2_hit = 1'b1;
            if ((sb.issue_rd == REG_IDX_W'(i)) && (count_q[i] == CW'(MAX_PENDING)))
                rd_full = 1'b1;
        end

        stall = sb.issue_valid && ((sb.issue_rs1_used && rs1_hit) ||
                                   (sb.issue_rs2_used && rs2_hit) ||
                                   (sb.issue_rd_write && rd_full));
        fire  = sb.issue_valid && !stall && sb.issue_rd_write;

        for (int i = 1; i < NUM_REGS; i++) begin
            inc[i] = fire && (sb.issue_rd == REG_IDX_W'(i));
            net    = int'(count_q[i]) + int'(inc[i]) - int'(dec_r[i]) - int'(dec_s[i]);
            if (net < 0) begin
                count_d[i] = '0;
                underflow  = 1'b1;
            end else begin
                count_d[i] = CW'(net);
            end
            busy_d[i] = count_d[i] != '0;
            total_d   = total_d + TW'(count_d[i]);
        end

        retire_oor = sb.retire_valid && ({1'b0, sb.retire_rd} >= (REG_IDX_W+1)'(NUM_REGS));
        squash_oor = sb.squash_valid && ({1'b0, sb.squash_rd} >= (REG_IDX_W+1)'(NUM_REGS));
        error_d    = error_q | underflow | retire_oor | squash_oor;
        stall_d    = (sb.issue_valid && stall && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count_q[i] <= '0;
            end
            busy_q  <= '0;
            total_q <= '0;
            error_q <= 1'b0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count_q[i] <= count_d[i];
            end
            busy_q  <= busy_d;
            total_q <= total_d;
            error_q <= error_d;
            stall_q <= stall_d;
        end
    end

    assign sb.issue_stall    = stall;
    assign sb.busy_mask      = busy_q;
    assign sb.inflight_total = total_q;
    assign sb.error          = error_q;
    assign sb.stall_cycles   = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench comparing two scoreboard instances (bypass off/on) to a counter model
module tb_hazard_scoreboard;
    localparam int NR = 32;
    localparam int IW = 6;
    localparam int MP = 3;

    typedef struct {
        bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit w;
        bit rv; int rr; bit sv; int sr;
    } stim_t;

    typedef struct {
        int inst; bit stall; bit [NR-1:0] busy; int total; bit err; longint stallc;
    } exp_t;

    logic clock, reset;

    hazard_scoreboard_if #(.NUM_REGS(NR), .REG_IDX_W(IW)) if0 ();
    hazard_scoreboard_if #(.NUM_REGS(NR), .REG_IDX_W(IW)) if1 ();

    hazard_scoreboard #(.NUM_REGS(NR), .REG_IDX_W(IW), .MAX_PENDING(MP), .RETIRE_BYPASS(0)) u_dut0 (
        .clock(clock), .reset(reset), .sb(if0));
    hazard_scoreboard #(.NUM_REGS(NR), .REG_IDX_W(IW), .MAX_PENDING(MP), .RETIRE_BYPASS(1)) u_dut1 (
        .clock(clock), .reset(reset), .sb(if1));

    int     mcnt [2][NR];
    bit     merr [2];
    longint mstl [2];
    exp_t   q [$];
    int     n_tests;
    int     n_fail;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic stim_t st(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit w,
                                 bit rv, int rr, bit sv, int sr);
        stim_t s;
        s.v = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.rd = rd; s.w = w;
        s.rv = rv; s.rr = rr; s.sv = sv; s.sr = sr;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input int k, input stim_t s);
        if (k == 0) begin
            if0.issue_valid = s.v;  if0.issue_rs1 = IW'(s.rs1); if0.issue_rs1_used = s.u1;
            if0.issue_rs2 = IW'(s.rs2); if0.issue_rs2_used = s.u2;
            if0.issue_rd = IW'(s.rd); if0.issue_rd_write = s.w;
            if0.retire_valid = s.rv; if0.retire_rd = IW'(s.rr);
            if0.squash_valid = s.sv; if0.squash_rd = IW'(s.sr);
        end else begin
            if1.issue_valid = s.v;  if1.issue_rs1 = IW'(s.rs1); if1.issue_rs1_used = s.u1;
            if1.issue_rs2 = IW'(s.rs2); if1.issue_rs2_used = s.u2;
            if1.issue_rd = IW'(s.rd); if1.issue_rd_write = s.w;
            if1.retire_valid = s.rv; if1.retire_rd = IW'(s.rr);
            if1.squash_valid = s.sv; if1.squash_rd = IW'(s.sr);
        end
    endtask

    function automatic bit src_hazard(int k, int rs, bit used, stim_t s);
        int e;
        if (!used || rs == 0 || rs >= NR) return 1'b0;
        e = mcnt[k][rs];
        if (k == 1) begin
            if (s.rv && s.rr == rs) e--;
            if (s.sv && s.sr == rs) e--;
        end
        return e > 0;
    endfunction

    function automatic bit model_stall(int k, stim_t s);
        bit full;
        full = s.w && s.rd != 0 && s.rd < NR && mcnt[k][s.rd] == MP;
        return s.v && (src_hazard(k, s.rs1, s.u1, s) || src_hazard(k, s.rs2, s.u2, s) || full);
    endfunction

    task automatic model_step(input int k, input stim_t s);
        exp_t e;
        int   nxt [NR];
        e.inst = k; e.busy = '0; e.total = 0; e.err = merr[k]; e.stallc = mstl[k];
        for (int i = 0; i < NR; i++) begin
            if (mcnt[k][i] != 0) e.busy[i] = 1'b1;
            e.total += mcnt[k][i];
            nxt[i] = mcnt[k][i];
        end
        e.stall = model_stall(k, s);
        q.push_back(e);
        if (s.v && !e.stall && s.w && s.rd != 0 && s.rd < NR) nxt[s.rd]++;
        if (s.rv) begin
            if (s.rr >= NR) merr[k] = 1'b1;
            else if (s.rr != 0) nxt[s.rr]--;
        end
        if (s.sv) begin
            if (s.sr >= NR) merr[k] = 1'b1;
            else if (s.sr != 0) nxt[s.sr]--;
        end
        for (int i = 0; i < NR; i++) begin
            if (nxt[i] < 0) begin nxt[i] = 0; merr[k] = 1'b1; end
            mcnt[k][i] = nxt[i];
        end
        if (s.v && e.stall && mstl[k] < 64'hFFFF_FFFF) mstl[k]++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) mcnt[k][i] = 0;
            merr[k] = 1'b0;
            mstl[k] = 0;
        end
    endtask

    task automatic cycle(input stim_t s0, input stim_t s1);
        @(posedge clock);
        #1;
        apply(0, s0);
        apply(1, s1);
        model_step(0, s0);
        model_step(1, s1);
    endtask

    task automatic cyc(input stim_t s);
        cycle(s, s);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        apply(0, idle());
        apply(1, idle());
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic stim_t rnd(int k);
        stim_t s;
        int    cand [$];
        s = idle();
        for (int i = 1; i < NR; i++) if (mcnt[k][i] > 0) cand.push_back(i);
        s.v  = $urandom_range(0, 3) != 0;
        s.u1 = $urandom_range(0, 1) == 1;
        s.u2 = $urandom_range(0, 1) == 1;
        s.rs1 = (cand.size() > 0 && $urandom_range(0, 1) == 1) ?
                cand[$urandom_range(0, cand.size() - 1)] : int'($urandom_range(0, NR - 1));
        s.rs2 = int'($urandom_range(0, NR - 1));
        s.w  = $urandom_range(0, 2) != 0;
        s.rd = int'($urandom_range(0, 9));
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            s.rv = 1'b1;
            s.rr = cand[$urandom_range(0, cand.size() - 1)];
        end
        if (cand.size() > 0 && $urandom_range(0, 3) == 0) begin
            s.sr = cand[$urandom_range(0, cand.size() - 1)];
            s.sv = !(s.rv && s.sr == s.rr && mcnt[k][s.sr] < 2);
        end
        return s;
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            while (q.size() > 0) begin
                exp_t      e;
                bit        a_stall, a_err;
                bit [NR-1:0] a_busy;
                longint    a_total, a_stc;
                e = q.pop_front();
                if (e.inst == 0) begin
                    a_stall = if0.issue_stall; a_busy = if0.busy_mask; a_total = if0.inflight_total;
                    a_err = if0.error; a_stc = if0.stall_cycles;
                end else begin
                    a_stall = if1.issue_stall; a_busy = if1.busy_mask; a_total = if1.inflight_total;
                    a_err = if1.error; a_stc = if1.stall_cycles;
                end
                chk("issue_stall", e.inst, a_stall, e.stall);
                chk("busy_mask", e.inst, a_busy, e.busy);
                chk("inflight_total", e.inst, a_total, e.total);
                chk("error", e.inst, a_err, e.err);
                chk("stall_cycles", e.inst, a_stc, e.stallc);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        apply(0, idle());
        apply(1, idle());
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(idle());

        // producer rd=5, dependent consumer, then release by retire
        cyc(st(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0));
        cyc(st(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(st(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(st(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0));
        cyc(st(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // register 0 is never tracked
        cyc(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc(st(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
        cyc(idle());

        // structural limit on rd=7
        repeat (3) cyc(st(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0));
        cyc(st(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0));
        cyc(st(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0));
        cyc(st(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0));
        repeat (3) cyc(st(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));

        // issue + retire + squash on rd=9 with two pending
        repeat (2) cyc(st(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0));
        cyc(st(1, 0, 0, 0, 0, 9, 1, 1, 9, 1, 9));
        cyc(st(1, 9, 1, 0, 0, 0, 0, 1, 9, 0, 0));
        cyc(idle());

        // underflow, then out-of-range indices
        cyc(st(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
        repeat (2) cyc(idle());
        do_reset();
        cyc(st(0, 0, 0, 0, 0, 0, 0, 1, 40, 0, 0));
        cyc(idle());
        do_reset();
        cyc(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 63));
        cyc(idle());
        do_reset();

        // ten stalled cycles
        cyc(st(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
        repeat (10) cyc(st(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        cyc(st(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
        cyc(idle());

        for (int n = 0; n < 400; n++) begin
            stim_t a, b;
            a = rnd(0);
            b = rnd(1);
            cycle(a, b);
        end

        // asynchronous reset between edges
        @(negedge clock);
        #2;
        apply(0, idle());
        apply(1, idle());
        reset = 1'b1;
        #1;
        chk("async_busy_mask", 0, if0.busy_mask, 0);
        chk("async_inflight_total", 0, if0.inflight_total, 0);
        chk("async_error", 0, if0.error, 0);
        chk("async_stall_cycles", 0, if0.stall_cycles, 0);
        chk("async_issue_stall", 0, if0.issue_stall, 0);
        chk("async_busy_mask", 1, if1.busy_mask, 0);
        chk("async_inflight_total", 1, if1.inflight_total, 0);
        chk("async_error", 1, if1.error, 0);
        chk("async_stall_cycles", 1, if1.stall_cycles, 0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) cyc(idle());
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
